// File: rtl/pipeline_run_ctrl.sv
// Run/step/breakpoint controller producing the pipelined core's clock enable.
// Commands from the debug unit start, single-step or halt the core. End-of-program
// drains the pipeline for a fixed number of cycles, and PC breakpoints stop a run.
module pipeline_run_ctrl #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned STAGES = 5,
    parameter int unsigned NUM_BP = 2,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd,
    input  logic [2:0]       cmd_idx,
    input  logic [PC_W-1:0]  cmd_arg,
    input  logic [PC_W-1:0]  pc,
    input  logic             pc_end,
    output logic             db_ena,
    output logic             busy,
    output logic             done,
    output logic             bp_hit,
    output logic [PC_W-1:0]  halted_pc,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [2:0] CmdRun   = 3'd1;
    localparam logic [2:0] CmdStep  = 3'd2;
    localparam logic [2:0] CmdHalt  = 3'd3;
    localparam logic [2:0] CmdSetBp = 3'd4;
    localparam logic [2:0] CmdClrBp = 3'd5;
    localparam logic [2:0] CmdClear = 3'd6;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StStep,
        StDrain,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       drain_q, drain_d;
    logic             db_ena_q, db_ena_d;
    logic             bp_hit_q, bp_hit_d;
    logic [PC_W-1:0]  halted_pc_q;
    logic             capture_pc;
    logic             clr_cnt;
    logic [CNT_W-1:0] cycle_count_q;

    logic [PC_W-1:0]  bp_addr_q [NUM_BP];
    logic [NUM_BP-1:0] bp_valid_q;
    logic             bp_match;
    logic             cmd_acc;
    logic             bp_wr;

    // Status decoded purely from the registered state.
    assign cmd_ready   = (state_q == StIdle) || (state_q == StRun) || (state_q == StDone);
    assign busy        = (state_q == StRun) || (state_q == StStep) || (state_q == StDrain);
    assign done        = (state_q == StDone);
    assign db_ena      = db_ena_q;
    assign bp_hit      = bp_hit_q;
    assign halted_pc   = halted_pc_q;
    assign cycle_count = cycle_count_q;

    assign cmd_acc = cmd_valid && cmd_ready;
    // Breakpoint slots are only editable while idle or running.
    assign bp_wr   = cmd_acc && ((state_q == StIdle) || (state_q == StRun)) &&
                     ((cmd == CmdSetBp) || (cmd == CmdClrBp));

    // Compare the current PC against every armed slot (pre-write contents).
    always_comb begin
        bp_match = 1'b0;
        for (int unsigned i = 0; i < NUM_BP; i++) begin
            if (bp_valid_q[i] && (bp_addr_q[i] == pc)) begin
                bp_match = 1'b1;
            end
        end
    end

    // Next-state logic; priority in RUN is pc_end, then HALT, then breakpoint.
    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        bp_hit_d   = 1'b0;
        capture_pc = 1'b0;
        clr_cnt    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_acc && (cmd == CmdRun)) begin
                    state_d = StRun;
                end else if (cmd_acc && (cmd == CmdStep)) begin
                    state_d = StStep;
                end
            end
            StRun: begin
                if (pc_end) begin
                    // The pc_end cycle counts as the first of STAGES enabled cycles.
                    state_d = (STAGES > 1) ? StDrain : StDone;
                    drain_d = 4'(STAGES - 1);
                end else if ((cmd_acc && (cmd == CmdHalt)) || bp_match) begin
                    state_d    = StIdle;
                    bp_hit_d   = bp_match;
                    capture_pc = bp_match;
                end
            end
            StStep: begin
                if (pc_end) begin
                    state_d = (STAGES > 1) ? StDrain : StDone;
                    drain_d = 4'(STAGES - 1);
                end else begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                drain_d = drain_q - 4'd1;
                if (drain_q <= 4'd1) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (cmd_acc && (cmd == CmdClear)) begin
                    state_d = StIdle;
                    clr_cnt = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        db_ena_d = (state_d == StRun) || (state_d == StStep) || (state_d == StDrain);
    end

    // Control state, registered enable, breakpoint pulse and captured PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            drain_q     <= 4'd0;
            db_ena_q    <= 1'b0;
            bp_hit_q    <= 1'b0;
            halted_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            db_ena_q <= db_ena_d;
            bp_hit_q <= bp_hit_d;
            if (capture_pc) begin
                halted_pc_q <= pc;
            end
        end
    end

    // Breakpoint slot storage; out-of-range slot indices are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bp_valid_q <= '0;
            for (int unsigned i = 0; i < NUM_BP; i++) begin
                bp_addr_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_BP; i++) begin
                if (bp_wr && (32'(cmd_idx) == i)) begin
                    if (cmd == CmdSetBp) begin
                        bp_addr_q[i]  <= cmd_arg;
                        bp_valid_q[i] <= 1'b1;
                    end else begin
                        bp_valid_q[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Saturating count of enabled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count_q <= '0;
        end else if (clr_cnt) begin
            cycle_count_q <= '0;
        end else if (db_ena_q && (cycle_count_q != {CNT_W{1'b1}})) begin
            cycle_count_q <= cycle_count_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Scoreboard bench for pipeline_run_ctrl: each enable burst is predicted up front and
// checked by a monitor when db_ena falls; a second instance has a 4-bit counter.
module tb_pipeline_run_ctrl;

    localparam logic [2:0] NOP = 3'd0, RUN = 3'd1, STEP = 3'd2, HALT = 3'd3;
    localparam logic [2:0] SETBP = 3'd4, CLRBP = 3'd5, CLEAR = 3'd6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd = NOP;
    logic [2:0]  cmd_idx = 3'd0;
    logic [31:0] cmd_arg = '0;
    logic [31:0] pc = '0;
    logic        pc_end = 1'b0;

    logic        cmd_ready, db_ena, busy, done, bp_hit;
    logic [31:0] halted_pc, cycle_count;
    logic        s_cmd_ready, s_db_ena, s_busy, s_done, s_bp_hit;
    logic [31:0] s_halted_pc;
    logic [3:0]  s_cycle_count;

    int total = 0;
    int bad = 0;

    typedef struct {
        int          len;
        logic        bp;
        logic        dn;
        logic [31:0] hpc;
        logic [31:0] cnt;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    pipeline_run_ctrl dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg), .pc(pc), .pc_end(pc_end),
        .db_ena(db_ena), .busy(busy), .done(done), .bp_hit(bp_hit),
        .halted_pc(halted_pc), .cycle_count(cycle_count)
    );

    pipeline_run_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
        .cmd(cmd), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg), .pc(pc), .pc_end(pc_end),
        .db_ena(s_db_ena), .busy(s_busy), .done(s_done), .bp_hit(s_bp_hit),
        .halted_pc(s_halted_pc), .cycle_count(s_cycle_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] c, input logic [2:0] idx, input logic [31:0] arg);
        cmd_valid = 1'b1;
        cmd       = c;
        cmd_idx   = idx;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
        cmd       = NOP;
    endtask

    task automatic push(input int len, input logic bp, input logic dn,
                        input logic [31:0] hpc, input logic [31:0] cnt);
        exp_t e;
        e.len = len; e.bp = bp; e.dn = dn; e.hpc = hpc; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_db_ena"}, db_ena, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_bp_hit"}, bp_hit, 0);
        check({tag, "_halted_pc"}, halted_pc, 0);
        check({tag, "_cycle_count"}, cycle_count, 0);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    // Monitor: measure each db_ena burst and score it when the enable drops.
    initial begin
        int   run_len;
        logic prev_ena;
        exp_t e;
        run_len  = 0;
        prev_ena = 1'b0;
        forever begin
            @(negedge clk);
            if (db_ena) begin
                run_len++;
            end else if (prev_ena) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL burst: unexpected burst of %0d cycles, want none", run_len);
                end else begin
                    e = exp_q.pop_front();
                    check("burst_len", 64'(run_len), 64'(e.len));
                    check("burst_bp_hit", bp_hit, e.bp);
                    check("burst_done", done, e.dn);
                    check("burst_halted_pc", halted_pc, e.hpc);
                    check("burst_cycle_count", cycle_count, e.cnt);
                end
                run_len = 0;
            end
            prev_ena = db_ena;
        end
    end

    initial begin
        // Reset state
        tick();
        tick();
        check_reset_vals("reset");
        reset = 1'b0;
        tick();

        // RUN, pc_end raised after 10 enabled cycles: 15 enabled cycles then DONE
        push(15, 0, 1, 32'h0, 32'd15);
        pc = 32'h100;
        issue(RUN, 0, 0);
        repeat (10) tick();
        pc_end = 1'b1;
        tick();
        pc_end = 1'b0;
        repeat (5) tick();
        check("t1_done", done, 1);
        check("t1_busy", busy, 0);

        // RUN in DONE is ignored; CLEAR returns to IDLE and zeroes the count
        issue(RUN, 0, 0);
        tick();
        check("done_run_ignored", done, 1);
        check("done_run_ena", db_ena, 0);
        issue(CLEAR, 0, 0);
        check("clear_done", done, 0);
        check("clear_count", cycle_count, 0);
        check("clear_ready", cmd_ready, 1);

        // Breakpoint at 0x10 with pc stepping 0,4,8,...
        issue(SETBP, 0, 32'h10);
        pc = 32'h0;
        push(5, 1, 0, 32'h10, 32'd5);
        issue(RUN, 0, 0);
        repeat (4) begin
            tick();
            pc = pc + 32'd4;
        end
        tick();
        pc = 32'h14;
        check("bp_pulse", bp_hit, 1);
        check("bp_ena_off", db_ena, 0);
        check("bp_halted_pc", halted_pc, 32'h10);
        tick();
        check("bp_single_pulse", bp_hit, 0);

        // Resume to pc_end: 4 RUN + 4 DRAIN cycles
        push(8, 0, 1, 32'h10, 32'd13);
        issue(RUN, 0, 0);
        repeat (3) begin
            tick();
            pc = pc + 32'd4;
        end
        pc_end = 1'b1;
        tick();
        pc_end = 1'b0;
        repeat (5) tick();
        issue(CLEAR, 0, 0);

        // Three single steps; pc sits on the armed breakpoint but STEP ignores it
        pc = 32'h10;
        for (int i = 1; i <= 3; i++) begin
            push(1, 0, 0, 32'h10, 32'(i));
            issue(STEP, 0, 0);
            check("step_ready", cmd_ready, 0);
            check("step_ena", db_ena, 1);
            tick();
            check("step_idle_ena", db_ena, 0);
        end
        check("step_count", cycle_count, 3);

        // pc_end and breakpoint on the same edge, then reset two cycles into DRAIN
        push(2, 0, 0, 32'h0, 32'h0);
        issue(RUN, 0, 0);
        pc_end = 1'b1;
        tick();
        pc_end = 1'b0;
        check("coincide_no_bp", bp_hit, 0);
        check("coincide_busy", busy, 1);
        tick();
        reset = 1'b1;
        tick();
        tick();
        check_reset_vals("drain_reset");
        reset = 1'b0;
        tick();

        // Out-of-range SET_BP is dropped; 20-cycle run saturates the 4-bit counter
        pc = 32'h40;
        issue(SETBP, 5, 32'h40);
        push(20, 0, 0, 32'h0, 32'd20);
        issue(RUN, 0, 0);
        repeat (19) tick();
        issue(HALT, 0, 0);
        check("sat_count", s_cycle_count, 4'hf);
        check("wide_count", cycle_count, 20);
        check("halt_idle", busy, 0);

        // HALT coinciding with a breakpoint still pulses bp_hit
        issue(SETBP, 1, 32'h80);
        pc = 32'h80;
        push(1, 1, 0, 32'h80, 32'd21);
        issue(RUN, 0, 0);
        issue(HALT, 0, 0);
        check("halt_bp_pulse", bp_hit, 1);
        check("halt_bp_pc", halted_pc, 32'h80);

        // SET_BP on the matching slot during RUN compares against old contents first
        pc = 32'h84;
        push(2, 1, 0, 32'h84, 32'd23);
        issue(RUN, 0, 0);
        issue(SETBP, 1, 32'h84);
        check("setbp_old_still_run", db_ena, 1);
        tick();
        check("setbp_new_hit", bp_hit, 1);
        repeat (3) tick();

        check("queue_empty", 64'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
